// File: rtl/reg_file_two_read_pkg.sv
// Shared constants for the two-read-port architectural register file.
// Sizes, the hard-wired zero register index and the zero/NOP data word.
package reg_file_two_read_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

endpackage : reg_file_two_read_pkg

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback, set wins on collision.
// Produces the two hazard lookups, masked where the write bypass already supplies data.
module reg_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] read_addr_one,
  input  logic [ADDR_W-1:0] read_addr_two,
  input  logic              bypass_one,
  input  logic              bypass_two,
  output logic              hazard_one,
  output logic              hazard_two
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      // NOTE: both updates are non-blocking to the same vector, so the later
      // statement wins on a shared address; set is placed last to take priority.
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_en) pending[set_addr] <= 1'b1;
    end
  end

  assign hazard_one = pending[read_addr_one] & ~bypass_one;
  assign hazard_two = pending[read_addr_two] & ~bypass_two;

endmodule : reg_scoreboard

// File: rtl/reg_file_two_read.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one synchronous write port, and a RAW-hazard scoreboard.
module reg_file_two_read #(
  parameter int DATA_W = reg_file_two_read_pkg::DATA_W,
  parameter int ADDR_W = reg_file_two_read_pkg::ADDR_W
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic [ADDR_W-1:0] in_read_addr_one,
  input  logic [ADDR_W-1:0] in_read_addr_two,
  output logic [DATA_W-1:0] ou_read_data_one,
  output logic [DATA_W-1:0] ou_read_data_two,
  input  logic              in_write_en,
  input  logic [ADDR_W-1:0] in_write_addr,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic              in_issue_en,
  input  logic [ADDR_W-1:0] in_issue_addr,
  output logic              ou_hazard_one,
  output logic              ou_hazard_two
);

  import reg_file_two_read_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic [DATA_W-1:0] ZERO_DATA = DATA_W'(ZERO_WORD);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              write_go;
  logic              issue_go;
  logic              bypass_one;
  logic              bypass_two;

  // An if on an X/Z enable falls to the default, so unknown enables act as 0.
  always_comb begin
    write_go = 1'b0;
    issue_go = 1'b0;
    if (in_write_en && (in_write_addr != ZERO_ADDR)) write_go = 1'b1;
    if (in_issue_en && (in_issue_addr != ZERO_ADDR)) issue_go = 1'b1;
  end

  assign bypass_one = write_go && (in_write_addr == in_read_addr_one);
  assign bypass_two = write_go && (in_write_addr == in_read_addr_two);

  // NOTE: the array is reset explicitly because every register must read 0
  // after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      mem <= '{default: '0};
    end else if (write_go) begin
      mem[in_write_addr] <= in_write_data;
    end
  end

  always_comb begin
    ou_read_data_one = mem[in_read_addr_one];
    ou_read_data_two = mem[in_read_addr_two];
    if (bypass_one) ou_read_data_one = in_write_data;
    if (bypass_two) ou_read_data_two = in_write_data;
    if (in_read_addr_one == ZERO_ADDR) ou_read_data_one = ZERO_DATA;
    if (in_read_addr_two == ZERO_ADDR) ou_read_data_two = ZERO_DATA;
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk           (in_clk),
    .rst_n         (in_rst_n),
    .set_en        (issue_go),
    .set_addr      (in_issue_addr),
    .clr_en        (write_go),
    .clr_addr      (in_write_addr),
    .read_addr_one (in_read_addr_one),
    .read_addr_two (in_read_addr_two),
    .bypass_one    (bypass_one),
    .bypass_two    (bypass_two),
    .hazard_one    (ou_hazard_one),
    .hazard_two    (ou_hazard_two)
  );

endmodule : reg_file_two_read

// File: tb/tb_reg_file_two_read.sv
// Self-checking bench for reg_file_two_read: directed vector table for the
// named scenarios, then random traffic against an array-based reference model.
module tb_reg_file_two_read;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          in_clk = 1'b0;
  logic          in_rst_n;
  logic [AW-1:0] in_read_addr_one, in_read_addr_two;
  logic [DW-1:0] ou_read_data_one, ou_read_data_two;
  logic          in_write_en;
  logic [AW-1:0] in_write_addr;
  logic [DW-1:0] in_write_data;
  logic          in_issue_en;
  logic [AW-1:0] in_issue_addr;
  logic          ou_hazard_one, ou_hazard_two;

  int errors = 0;
  int checks = 0;

  always #5 in_clk = ~in_clk;

  reg_file_two_read dut (
    .in_clk           (in_clk),
    .in_rst_n         (in_rst_n),
    .in_read_addr_one (in_read_addr_one),
    .in_read_addr_two (in_read_addr_two),
    .ou_read_data_one (ou_read_data_one),
    .ou_read_data_two (ou_read_data_two),
    .in_write_en      (in_write_en),
    .in_write_addr    (in_write_addr),
    .in_write_data    (in_write_data),
    .in_issue_en      (in_issue_en),
    .in_issue_addr    (in_issue_addr),
    .ou_hazard_one    (ou_hazard_one),
    .ou_hazard_two    (ou_hazard_two)
  );

  typedef struct {
    logic          rst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ie;
    logic [AW-1:0] iaddr;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          h1;
    logic          h2;
  } vec_t;

  // Reference model state: plain register contents and pending flags.
  logic [DW-1:0] model_mem  [DEPTH];
  bit            model_pend [DEPTH];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic we, input logic [AW-1:0] waddr,
                       input logic [DW-1:0] wdata, input logic ie, input logic [AW-1:0] iaddr,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    @(negedge in_clk);
    in_rst_n         = rst_n;
    in_write_en      = we;
    in_write_addr    = waddr;
    in_write_data    = wdata;
    in_issue_en      = ie;
    in_issue_addr    = iaddr;
    in_read_addr_one = ra1;
    in_read_addr_two = ra2;
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                               input logic h1, input logic h2);
    check({tag, " data_one"},   ou_read_data_one, d1);
    check({tag, " data_two"},   ou_read_data_two, d2);
    check({tag, " hazard_one"}, DW'(ou_hazard_one), DW'(h1));
    check({tag, " hazard_two"}, DW'(ou_hazard_two), DW'(h2));
  endtask

  // Expected combinational outputs for one read address, from the behavioural rules.
  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] ra, input logic we,
                                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (ra == 0) return '0;
    if (we && wa == ra) return wd;
    return model_mem[ra];
  endfunction

  function automatic logic model_haz(input logic [AW-1:0] ra, input logic we, input logic [AW-1:0] wa);
    if (we && wa != 0 && wa == ra) return 1'b0;
    return model_pend[ra];
  endfunction

  vec_t vecs [16];

  initial begin
    in_rst_n = 1'b0; in_write_en = 1'b0; in_write_addr = '0; in_write_data = '0;
    in_issue_en = 1'b0; in_issue_addr = '0; in_read_addr_one = '0; in_read_addr_two = '0;

    //          rst we waddr wdata          ie iaddr ra1 ra2  d1            d2            h1 h2
    vecs[0]  = '{1, 1, 5,  32'hDEADBEEF, 0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0};
    vecs[1]  = '{1, 0, 0,  32'h0,        0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    vecs[2]  = '{1, 1, 0,  32'h12345678, 1, 0,  0,  0,  32'h0,        32'h0,        0, 0};
    vecs[3]  = '{1, 0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        32'h0,        0, 0};
    vecs[4]  = '{1, 1, 7,  32'hA5A5A5A5, 1, 3,  7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0};
    vecs[5]  = '{1, 0, 0,  32'h0,        0, 0,  3,  7,  32'h0,        32'hA5A5A5A5, 1, 0};
    vecs[6]  = '{1, 1, 3,  32'h55,       1, 3,  3,  5,  32'h55,       32'hDEADBEEF, 0, 0};
    vecs[7]  = '{1, 0, 0,  32'h0,        0, 0,  3,  3,  32'h55,       32'h55,       1, 1};
    vecs[8]  = '{1, 1, 3,  32'h66,       0, 0,  3,  0,  32'h66,       32'h0,        0, 0};
    vecs[9]  = '{1, 0, 0,  32'h0,        0, 0,  3,  3,  32'h66,       32'h66,       0, 0};
    vecs[10] = '{1, 1, 9,  32'h11,       1, 9,  9,  10, 32'h11,       32'h0,        0, 0};
    vecs[11] = '{1, 1, 3,  32'h77,       1, 10, 9,  3,  32'h11,       32'h77,       1, 0};
    vecs[12] = '{1, 0, 0,  32'h0,        0, 0,  9,  10, 32'h11,       32'h0,        1, 1};
    vecs[13] = '{0, 0, 0,  32'h0,        1, 4,  3,  10, 32'h77,       32'h0,        0, 1};
    vecs[14] = '{1, 0, 0,  32'h0,        0, 0,  9,  10, 32'h0,        32'h0,        0, 0};
    vecs[15] = '{1, 0, 0,  32'h0,        0, 0,  4,  3,  32'h0,        32'h0,        0, 0};

    // Reset for one edge, then sweep every address on both ports.
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 1'b0, '0, '0, 1'b0, '0, AW'(a), AW'(DEPTH - 1 - a));
      check_outputs($sformatf("reset_sweep a=%0d", a), '0, '0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst_n, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
            vecs[i].ie, vecs[i].iaddr, vecs[i].ra1, vecs[i].ra2);
      check_outputs($sformatf("vec%0d", i), vecs[i].d1, vecs[i].d2, vecs[i].h1, vecs[i].h2);
    end

    // Random traffic from a fresh reset, addresses biased toward a small set for collisions.
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    for (int r = 0; r < DEPTH; r++) begin
      model_mem[r]  = '0;
      model_pend[r] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      logic          rst_n, we, ie;
      logic [AW-1:0] wa, ia, ra1, ra2;
      logic [DW-1:0] wd;
      rst_n = ($urandom_range(0, 39) != 0);
      we    = 1'($urandom_range(0, 1));
      ie    = 1'($urandom_range(0, 1));
      wa    = AW'($urandom_range(0, 7));
      ia    = AW'($urandom_range(0, 7));
      ra1   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ra2   = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom_range(0, 7));
      wd    = DW'($urandom);
      drive(rst_n, we, wa, wd, ie, ia, ra1, ra2);
      check_outputs($sformatf("rand%0d", n),
                    model_data(ra1, we, wa, wd), model_data(ra2, we, wa, wd),
                    model_haz(ra1, we, wa), model_haz(ra2, we, wa));
      if (!rst_n) begin
        for (int r = 0; r < DEPTH; r++) begin
          model_mem[r]  = '0;
          model_pend[r] = 1'b0;
        end
      end else begin
        if (we && wa != 0) begin
          model_mem[wa]  = wd;
          model_pend[wa] = 1'b0;
        end
        if (ie && ia != 0) model_pend[ia] = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_file_two_read
